// File: rtl/cart_loader.sv
// Cartridge download loader: copies ioctl bytes into cartridge memory, then pads the rest.
// Optional CART_LOADER_CHECKSUM_EN adds cart_sum, a modulo-256 sum of the loaded bytes.
module cart_loader #(
  parameter int         CART_AW    = 15,
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  output logic               ioctl_wait,
  output logic [CART_AW-1:0] cart_addr,
  output logic [7:0]         cart_wdata,
  output logic               cart_we,
  input  logic               cart_busy,
  output logic [CART_AW:0]   cart_size,
  output logic               cart_valid,
  output logic               cart_overflow,
  output logic               core_reset
`ifdef CART_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]         cart_sum
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic             start;
  logic             in_range;
  logic             write_done;
  logic             load_entry;
  logic [CART_AW:0] addr_inc;

  assign start      = ioctl_download && (ioctl_index == CART_INDEX);
  assign in_range   = (ioctl_addr >> CART_AW) == 25'd0;
  assign write_done = cart_we && !cart_busy;
  assign addr_inc   = {1'b0, cart_addr} + (CART_AW+1)'(1);
  assign core_reset = (state == S_LOAD) || (state == S_WRITE) || (state == S_PAD);

  // A new download in PAD only takes over once the in-flight pad write has completed.
  assign load_entry = (((state == S_IDLE) || (state == S_DONE)) && start) ||
                      ((state == S_PAD) && write_done && start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cart_addr     <= '0;
      cart_wdata    <= '0;
      cart_we       <= 1'b0;
      ioctl_wait    <= 1'b0;
      cart_size     <= '0;
      cart_valid    <= 1'b0;
      cart_overflow <= 1'b0;
    end else if (load_entry) begin
      state         <= S_LOAD;
      cart_we       <= 1'b0;
      cart_size     <= '0;
      cart_valid    <= 1'b0;
      cart_overflow <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (!ioctl_download) begin
            // A fully loaded image has nothing left to pad.
            if (cart_size[CART_AW]) begin
              state      <= S_DONE;
              cart_valid <= 1'b1;
            end else begin
              state      <= S_PAD;
              cart_addr  <= cart_size[CART_AW-1:0];
              cart_wdata <= PAD_BYTE;
              cart_we    <= 1'b1;
            end
          end else if (ioctl_wr) begin
            if (in_range) begin
              state      <= S_WRITE;
              cart_addr  <= ioctl_addr[CART_AW-1:0];
              cart_wdata <= ioctl_dout;
              cart_we    <= 1'b1;
              ioctl_wait <= 1'b1;
            end else begin
              cart_overflow <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (write_done) begin
            state      <= S_LOAD;
            cart_we    <= 1'b0;
            ioctl_wait <= 1'b0;
            if (addr_inc > cart_size) cart_size <= addr_inc;
          end
        end
        S_PAD: begin
          if (write_done) begin
            if (&cart_addr) begin
              state      <= S_DONE;
              cart_we    <= 1'b0;
              cart_valid <= (cart_size != '0);
            end else begin
              cart_addr <= cart_addr + CART_AW'(1);
            end
          end
        end
        S_IDLE, S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cart_sum <= '0;
    end else if (load_entry) begin
      cart_sum <= '0;
    end else if ((state == S_WRITE) && write_done) begin
      cart_sum <= cart_sum + cart_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_cart_loader.sv
// Self-checking bench for cart_loader: a write scoreboard built from the download rules
// plus directed scenarios for stalls, overflow, foreign index, reset and abort.
module tb_cart_loader;
  localparam int AW  = 15;
  localparam int TOP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait;
  logic [AW-1:0] cart_addr;
  logic [7:0]    cart_wdata;
  logic          cart_we;
  logic          cart_busy = 1'b0;
  logic [AW:0]   cart_size;
  logic          cart_valid;
  logic          cart_overflow;
  logic          core_reset;
`ifdef CART_LOADER_CHECKSUM_EN
  logic [7:0]    cart_sum;
`endif

  cart_loader #(.CART_AW(AW), .CART_INDEX(8'd1), .PAD_BYTE(8'hFF)) dut (
    .clk(clk), .reset(rst),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cart_addr(cart_addr), .cart_wdata(cart_wdata), .cart_we(cart_we), .cart_busy(cart_busy),
    .cart_size(cart_size), .cart_valid(cart_valid), .cart_overflow(cart_overflow),
    .core_reset(core_reset)
`ifdef CART_LOADER_CHECKSUM_EN
    , .cart_sum(cart_sum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: expected completed writes in order, plus running size/sum of the current download.
  logic [22:0] exp_q[$];
  int          m_size;
  logic [7:0]  m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: stall stability and wait/we relation at negedge, completions at posedge.
  logic          p_cmp = 1'b0;
  logic          hold  = 1'b0;
  logic [AW-1:0] p_addr, h_addr;
  logic [7:0]    p_data, h_data;

  always @(negedge clk) begin
    if (hold && !rst) begin
      chk("hold_we", {31'd0, cart_we}, 32'd1);
      chk("hold_addr_data", {9'd0, cart_addr, cart_wdata}, {9'd0, h_addr, h_data});
    end
    chk("wait_without_we", {31'd0, ioctl_wait & ~cart_we}, 32'd0);
    p_cmp  = cart_we && !cart_busy;
    hold   = cart_we && cart_busy;
    p_addr = cart_addr;
    p_data = cart_wdata;
    h_addr = cart_addr;
    h_data = cart_wdata;
  end

  always @(posedge clk) begin
    if (p_cmp === 1'b1 && rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", p_addr, p_data);
      end else begin
        chk("write_seq", {9'd0, p_addr, p_data}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_start();
    m_size = 0;
    m_sum  = 8'd0;
  endtask

  // Sends one byte; busy_n cycles of cart_busy on its write. Returns ioctl_wait-high cycles.
  task automatic send(input logic [24:0] a, input logic [7:0] d, input int busy_n, output int hi);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    cart_busy  = (busy_n > 0);
    cyc(1);
    ioctl_wr = 1'b0;
    if (a < 25'(TOP)) begin
      exp_q.push_back({a[AW-1:0], d});
      if (int'(a) + 1 > m_size) m_size = int'(a) + 1;
      m_sum = m_sum + d;
    end
    hi = 0;
    for (int k = 0; k < 64 && ioctl_wait; k++) begin
      hi++;
      chk("stall_addr_data", {9'd0, cart_addr, cart_wdata}, {9'd0, a[AW-1:0], d});
      if (hi > busy_n) cart_busy = 1'b0;
      cyc(1);
    end
    cart_busy = 1'b0;
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    for (int i = m_size; i < TOP; i++) exp_q.push_back({AW'(i), 8'hFF});
  endtask

  task automatic wait_pad_addr(input logic [AW-1:0] target);
    int n = 0;
    while (!(cart_we && cart_addr == target) && n < 4000) begin
      cyc(1);
      n++;
    end
    chk("reach_pad_addr", {17'd0, cart_addr}, {17'd0, target});
  endtask

  initial begin
    int hi;
    int n;
    model_start();
    cyc(3);
    chk("rst_we_wait", {30'd0, cart_we, ioctl_wait}, 32'd0);
    chk("rst_valid_ovf_core", {29'd0, cart_valid, cart_overflow, core_reset}, 32'd0);
    chk("rst_size", {16'd0, cart_size}, 32'd0);
    chk("rst_addr_data", {9'd0, cart_addr, cart_wdata}, 32'd0);
`ifdef CART_LOADER_CHECKSUM_EN
    chk("rst_sum", {24'd0, cart_sum}, 32'd0);
`endif
    rst = 1'b0;
    cyc(2);

    // Foreign index: nothing happens.
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    cyc(1);
    ioctl_wr = 1'b1;
    ioctl_addr = '0;
    ioctl_dout = 8'h99;
    cyc(1);
    ioctl_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("idx0_core_wait", {30'd0, core_reset, ioctl_wait}, 32'd0);
      cyc(1);
    end
    ioctl_download = 1'b0;
    cyc(2);

    // Four bytes, first write stalled 3 cycles, then full pad.
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    model_start();
    cyc(2);
    chk("load_core_reset", {31'd0, core_reset}, 32'd1);
    send(25'h0, 8'h11, 3, hi);
    chk("stall_wait_cycles", hi, 32'd4);
    send(25'h1, 8'h22, 0, hi);
    chk("wait_cycles_b1", hi, 32'd1);
    send(25'h2, 8'h33, 0, hi);
    send(25'h3, 8'h44, 0, hi);
    chk("size_after_4", {16'd0, cart_size}, 32'd4);
    end_download();
    n = 0;
    while (core_reset && n < 40000) begin
      cyc(1);
      n++;
    end
    cyc(1);
    chk("pad_all_written", exp_q.size(), 32'd0);
    chk("done_size", {16'd0, cart_size}, 32'd4);
    chk("done_size_model", {16'd0, cart_size}, m_size);
    chk("done_valid_ovf_core", {29'd0, cart_valid, cart_overflow, core_reset}, 32'b100);
`ifdef CART_LOADER_CHECKSUM_EN
    chk("done_sum", {24'd0, cart_sum}, 32'hAA);
    chk("done_sum_model", {24'd0, cart_sum}, {24'd0, m_sum});
`endif

    // Overflow byte, one in-range byte, then reset during pad.
    ioctl_download = 1'b1;
    model_start();
    cyc(2);
    chk("reload_clears_valid", {31'd0, cart_valid}, 32'd0);
    send(25'h8000, 8'h77, 0, hi);
    chk("ovf_wait_cycles", hi, 32'd0);
    chk("ovf_flag", {31'd0, cart_overflow}, 32'd1);
    send(25'h10, 8'h55, 0, hi);
    chk("size_after_0x10", {16'd0, cart_size}, 32'h11);
    end_download();
    wait_pad_addr(AW'(16'h100));
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_mid_pad_we_core", {30'd0, cart_we, core_reset}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("after_rst_valid_ovf", {30'd0, cart_valid, cart_overflow}, 32'd0);
    chk("after_rst_size", {16'd0, cart_size}, 32'd0);

    // Empty download padding from 0, aborted at 0x200 by a new download.
    ioctl_download = 1'b1;
    model_start();
    cyc(2);
    end_download();
    wait_pad_addr(AW'(16'h200));
    ioctl_download = 1'b1;
    exp_q.delete();
    exp_q.push_back({AW'(16'h200), 8'hFF});
    model_start();
    cyc(3);
    chk("abort_inflight_only", exp_q.size(), 32'd0);
    chk("abort_size", {16'd0, cart_size}, 32'd0);
    chk("abort_core_reset", {31'd0, core_reset}, 32'd1);
    send(25'h0, 8'hA5, 0, hi);
    send(25'h1, 8'h5A, 0, hi);
    chk("abort_reload_size", {16'd0, cart_size}, 32'd2);
    chk("abort_reload_done", exp_q.size(), 32'd0);
`ifdef CART_LOADER_CHECKSUM_EN
    chk("abort_reload_sum", {24'd0, cart_sum}, 32'hFF);
`endif
    rst = 1'b1;
    ioctl_download = 1'b0;
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
